// File: rtl/cp0.sv
// Purpose: MIPS-style coprocessor 0 (Count, Compare, Status, Cause, EPC, PRId) with exception/ERET state and interrupt request.
// Latency: reads are combinational with same-cycle write bypass; writes, exceptions and ERET commit at the next rising clk edge.
// Backpressure: none; every read, write, exception and ERET is accepted in the cycle it is presented.
// Optional feature: define CP0_TIMER_EN to build Count/Compare and the timer interrupt on IP[7]; undefined, both read 0.
module cp0 (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic [4:0]  read_addr,
    output logic [31:0] read_data,
    input  logic        write_en,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    input  logic [5:0]  hw_int,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_delay_slot,
    input  logic        eret,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_req
);

    localparam logic [4:0]  REG_COUNT   = 5'd9;
    localparam logic [4:0]  REG_COMPARE = 5'd11;
    localparam logic [4:0]  REG_STATUS  = 5'd12;
    localparam logic [4:0]  REG_CAUSE   = 5'd13;
    localparam logic [4:0]  REG_EPC     = 5'd14;
    localparam logic [4:0]  REG_PRID    = 5'd15;
    localparam logic [31:0] PRID_VALUE  = 32'h0000_4220;

    // Status state: only IM, EXL and IE are stored; BEV is a constant 1
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;

    // Cause state: BD, sampled hardware lines, software IP and ExcCode
    logic        bd_q;
    logic [5:0]  hw_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  exc_code_q;
    logic [7:0]  ip;

    logic [31:0] epc_q;
    logic        timer_flag;

    // Write decodes
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        rd_bypass;

    assign wr_status = write_en && (write_addr == REG_STATUS);
    assign wr_cause  = write_en && (write_addr == REG_CAUSE);
    assign wr_epc    = write_en && (write_addr == REG_EPC);
    assign rd_bypass = write_en && (write_addr == read_addr);

`ifdef CP0_TIMER_EN
    logic        wr_count;
    logic        wr_compare;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] count_nxt;
    logic        count_upd;
    logic        toggle_q;

    assign wr_count   = write_en && (write_addr == REG_COUNT);
    assign wr_compare = write_en && (write_addr == REG_COMPARE);

    // Next Count value: a software write wins over the half-rate increment
    always_comb begin
        count_nxt = count_q;
        count_upd = 1'b0;
        if (wr_count) begin
            count_nxt = write_data;
            count_upd = 1'b1;
        end else if (toggle_q) begin
            count_nxt = count_q + 32'd1;
            count_upd = 1'b1;
        end
    end

    // Count/Compare registers, half-rate toggle and sticky timer flag.
    // The match is only taken when Count moves, so Count==Compare==0
    // straight out of reset does not raise a spurious timer interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            compare_q  <= '0;
            toggle_q   <= 1'b0;
            timer_flag <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            toggle_q <= wr_count ? 1'b0 : ~toggle_q;
            if (wr_compare) begin
                compare_q <= write_data;
            end
            if (wr_compare) begin
                timer_flag <= 1'b0;
            end else if (count_upd && (count_nxt == compare_q)) begin
                timer_flag <= 1'b1;
            end
        end
    end
`else
    assign timer_flag = 1'b0;
`endif

    // Status: exception sets EXL, ERET clears it, software write lowest priority
    always_ff @(posedge clk) begin
        if (rst) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
        end else begin
            if (wr_status) begin
                im_q <= write_data[15:8];
                ie_q <= write_data[0];
            end
            if (exc_valid) begin
                exl_q <= 1'b1;
            end else if (eret) begin
                exl_q <= 1'b0;
            end else if (wr_status) begin
                exl_q <= write_data[1];
            end
        end
    end

    // Cause: hardware lines sampled every cycle; BD only captured on a first-level exception
    always_ff @(posedge clk) begin
        if (rst) begin
            bd_q       <= 1'b0;
            hw_q       <= '0;
            ip_sw_q    <= '0;
            exc_code_q <= '0;
        end else begin
            hw_q <= hw_int;
            if (wr_cause) begin
                ip_sw_q <= write_data[9:8];
            end
            if (exc_valid) begin
                exc_code_q <= exc_code;
                if (!exl_q) begin
                    bd_q <= exc_delay_slot;
                end
            end
        end
    end

    // EPC: a nested exception (EXL already set) leaves the original return address intact
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q <= '0;
        end else if (exc_valid && !exl_q) begin
            epc_q <= exc_delay_slot ? (exc_pc - 32'd4) : exc_pc;
        end else if (wr_epc) begin
            epc_q <= write_data;
        end
    end

    assign ip       = {hw_q[5] | timer_flag, hw_q[4:0], ip_sw_q};
    assign status_o = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_o  = {bd_q, 15'b0, ip, 1'b0, exc_code_q, 2'b0};
    assign epc_o    = epc_q;
    assign int_req  = ie_q & ~exl_q & (|(ip & im_q));

    // Read mux; a same-cycle write to the read register forwards its writable fields
    always_comb begin
        read_data = '0;
        if (read_en) begin
            case (read_addr)
`ifdef CP0_TIMER_EN
                REG_COUNT:   read_data = rd_bypass ? write_data : count_q;
                REG_COMPARE: read_data = rd_bypass ? write_data : compare_q;
`endif
                REG_STATUS:  read_data = rd_bypass ? {status_o[31:16], write_data[15:8], status_o[7:2], write_data[1:0]}
                                                   : status_o;
                REG_CAUSE:   read_data = rd_bypass ? {cause_o[31:10], write_data[9:8], cause_o[7:0]}
                                                   : cause_o;
                REG_EPC:     read_data = rd_bypass ? write_data : epc_q;
                REG_PRID:    read_data = PRID_VALUE;
                default:     read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: table of one-cycle stimulus records checked through an expected-result queue,
// followed by hand sequences for bypass, reset priority, timer match/clear and Count wrap.
// Timer expectations follow the CP0_TIMER_EN build of the design.
module tb_cp0;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en;
    logic [4:0]  read_addr;
    logic [31:0] read_data;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [5:0]  hw_int;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_delay_slot;
    logic        eret;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_req;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0 dut (
        .clk            (clk),
        .rst            (rst),
        .read_en        (read_en),
        .read_addr      (read_addr),
        .read_data      (read_data),
        .write_en       (write_en),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .hw_int         (hw_int),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_delay_slot (exc_delay_slot),
        .eret           (eret),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .int_req        (int_req)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        exc;
        logic [4:0]  ec;
        logic [31:0] pc;
        logic        ds;
        logic        er;
        logic [5:0]  hw;
        logic [4:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_int;
    } vec_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [4:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_int;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic exc, input logic [4:0] ec, input logic [31:0] pc,
                                input logic ds, input logic er, input logic [5:0] hw,
                                input logic [4:0] ra, input logic [31:0] rd, input logic ei);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.exc = exc; v.ec = ec; v.pc = pc; v.ds = ds;
        v.er = er; v.hw = hw;
        v.ra = ra; v.exp_rd = rd; v.exp_int = ei;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctl();
        write_en = 1'b0; write_addr = '0; write_data = '0;
        exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_delay_slot = 1'b0;
        eret = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        read_en = 1'b1;
        read_addr = a;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write_en = 1'b1; write_addr = a; write_data = d;
        tick();
        idle_ctl();
    endtask

    initial begin
        vec_t v;
        sb_t  e;

        rst = 1'b1; read_en = 1'b0; read_addr = '0; hw_int = '0;
        idle_ctl();

        //         we  wa      wd             exc ec     pc             ds  er  hw         ra      expected rd                  int
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd12, 32'h0040_0000,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd15, 32'h0000_4220,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd3,  32'h0000_0000,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd13, 32'h0000_0000,               0));
        vecs.push_back(mk(1, 5'd12, 32'h0000_FF03, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd12, 32'h0040_FF03,               0));
        vecs.push_back(mk(1, 5'd12, 32'hFFFF_FFFF, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd12, 32'h0040_FF03,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000001, 5'd13, 32'h0000_0400,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 1, 6'b000001, 5'd12, 32'h0040_FF01,               1));
        vecs.push_back(mk(1, 5'd12, 32'h0000_0101, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd12, 32'h0040_0101,               0));
        vecs.push_back(mk(1, 5'd13, 32'hFFFF_FFFF, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd13, 32'h0000_0300,               1));
        vecs.push_back(mk(1, 5'd13, 32'h0000_0000, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd13, 32'h0000_0000,               0));
        vecs.push_back(mk(1, 5'd14, 32'hDEAD_BEEF, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd14, 32'hDEAD_BEEF,               0));
        vecs.push_back(mk(1, 5'd3,  32'h1234_5678, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd3,  32'h0000_0000,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b100000, 5'd13, 32'h0000_8000,               0));
        vecs.push_back(mk(1, 5'd12, 32'h0000_8001, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd13, 32'h0000_0000,               0));
        vecs.push_back(mk(1, 5'd9,  32'h0000_0055, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd9,  TIMER ? 32'h55 : 32'h0,      0));
        vecs.push_back(mk(1, 5'd11, 32'h7777_0000, 0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd11, TIMER ? 32'h7777_0000 : 32'h0, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         1, 5'd8, 32'hBFC0_0100, 1, 0, 6'b000000, 5'd14, 32'hBFC0_00FC,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd13, 32'h8000_0020,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd12, 32'h0040_8003,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         1, 5'd4, 32'h8000_1000, 0, 0, 6'b000000, 5'd14, 32'hBFC0_00FC,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd13, 32'h8000_0010,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 1, 6'b000000, 5'd12, 32'h0040_8001,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         1, 5'd5, 32'h8000_0200, 0, 0, 6'b000000, 5'd14, 32'h8000_0200,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd13, 32'h0000_0014,               0));
        vecs.push_back(mk(1, 5'd12, 32'h0000_0003, 0, 5'd0, 32'h0,         0, 1, 6'b000000, 5'd12, 32'h0040_0001,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         1, 5'd0, 32'h0000_0100, 0, 1, 6'b000000, 5'd12, 32'h0040_0003,               0));
        vecs.push_back(mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 6'b000000, 5'd14, 32'h0000_0100,               0));
        vecs.push_back(mk(1, 5'd14, 32'hCAFE_F00D, 1, 5'd2, 32'h0000_0500, 0, 0, 6'b000000, 5'd14, 32'hCAFE_F00D,               0));
        vecs.push_back(mk(1, 5'd13, 32'h0000_0300, 1, 5'd3, 32'h0000_0600, 1, 0, 6'b000000, 5'd13, 32'h0000_030C,               0));

        // reset state, checked while rst is still asserted
        tick();
        tick();
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        check("rst_int", {31'b0, int_req}, 32'h0);
        rst = 1'b0;

        // table: drive one cycle, queue the expectation, compare after the edge
        foreach (vecs[i]) begin
            v = vecs[i];
            read_en = 1'b0;
            write_en = v.we; write_addr = v.wa; write_data = v.wd;
            exc_valid = v.exc; exc_code = v.ec; exc_pc = v.pc; exc_delay_slot = v.ds;
            eret = v.er; hw_int = v.hw;
            sb_q.push_back('{idx: 8'(i), ra: v.ra, exp_rd: v.exp_rd, exp_int: v.exp_int});
            tick();
            idle_ctl();
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL vec%0d_queue: got empty queue expected one entry", i);
            end else begin
                e = sb_q.pop_front();
                rd(e.ra);
                check($sformatf("vec%0d_rd", e.idx), read_data, e.exp_rd);
                check($sformatf("vec%0d_int", e.idx), {31'b0, int_req}, {31'b0, e.exp_int});
            end
        end

        // read_en low forces zero
        read_en = 1'b0; read_addr = 5'd15; #1;
        check("rd_gate", read_data, 32'h0);

        // same-cycle write/read bypass, before the edge
        write_en = 1'b1; write_addr = 5'd14; write_data = 32'h1234_5678;
        rd(5'd14);
        check("byp_epc", read_data, 32'h1234_5678);
        write_addr = 5'd12; write_data = 32'hFFFF_FFFF;
        rd(5'd12);
        check("byp_status", read_data, 32'h0040_FF03);
        tick();
        idle_ctl();

        // reset wins over exception, ERET and write on the same edge
        rst = 1'b1; exc_valid = 1'b1; exc_code = 5'd9; exc_pc = 32'h1000; exc_delay_slot = 1'b1;
        eret = 1'b1; write_en = 1'b1; write_addr = 5'd14; write_data = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        idle_ctl();
        check("rst2_status", status_o, 32'h0040_0000);
        check("rst2_cause", cause_o, 32'h0);
        check("rst2_epc", epc_o, 32'h0);
        check("rst2_int", {31'b0, int_req}, 32'h0);

        // timer match, sticky flag and clear on Compare write
        wr(5'd11, 32'd10);
        wr(5'd12, 32'h0000_8001);
        wr(5'd9, 32'd0);
        repeat (19) tick();
        rd(5'd9);
        check("tmr_count_19", read_data, TIMER ? 32'd9 : 32'd0);
        check("tmr_ip15_pre", {31'b0, cause_o[15]}, 32'h0);
        check("tmr_int_pre", {31'b0, int_req}, 32'h0);
        tick();
        rd(5'd9);
        check("tmr_count_20", read_data, TIMER ? 32'd10 : 32'd0);
        check("tmr_ip15_hit", {31'b0, cause_o[15]}, {31'b0, TIMER});
        check("tmr_int_hit", {31'b0, int_req}, {31'b0, TIMER});
        repeat (4) tick();
        check("tmr_sticky", {31'b0, cause_o[15]}, {31'b0, TIMER});
        wr(5'd11, 32'd10);
        check("tmr_ip15_clr", {31'b0, cause_o[15]}, 32'h0);
        check("tmr_int_clr", {31'b0, int_req}, 32'h0);
        repeat (4) tick();
        check("tmr_stay_clr", {31'b0, cause_o[15]}, 32'h0);

        // Count wrap two cycles after writing all ones
        wr(5'd9, 32'hFFFF_FFFF);
        rd(5'd9);
        check("wrap_t0", read_data, TIMER ? 32'hFFFF_FFFF : 32'h0);
        tick();
        rd(5'd9);
        check("wrap_t1", read_data, TIMER ? 32'hFFFF_FFFF : 32'h0);
        tick();
        rd(5'd9);
        check("wrap_t2", read_data, 32'h0);

        // hw_int[5] alone drives IP[15] and the interrupt through IM[7]
        hw_int = 6'b100000;
        tick();
        check("hw5_cause", cause_o, 32'h0000_8000);
        check("hw5_int", {31'b0, int_req}, 32'h1);
        hw_int = 6'b000000;
        tick();
        check("hw5_clr", cause_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 read_en  in  1  CP0 read request (MFC0 in ID).
REQ-005 read_addr  in  5  CP0 register number to read.
REQ-006 read_data  out  32  read result.
REQ-007 write_en  in  1  CP0 write request (MTC0 commit).
REQ-008 write_addr  in  5  CP0 register number to write.
REQ-009 write_data  in  32  write value.
REQ-010 hw_int  in  6  external interrupt lines, level-sensitive.
REQ-011 exc_valid  in  1  exception commit this cycle.
REQ-012 exc_code  in  5  ExcCode of committing exception.
REQ-013 exc_pc  in  32  PC of faulting instruction.
REQ-014 exc_delay_slot  in  1  faulting instruction is in a delay slot.
REQ-015 eret  in  1  ERET commit this cycle.
REQ-016 status_o / cause_o / epc_o  out  32 each  current register values.
REQ-017 int_req  out  1  interrupt pending and enabled.

Function
REQ-018 Implemented registers: Count (9), Compare (11), Status (12), Cause (13), EPC (14), PRId (15, constant 0x0000_4220); all other numbers read 0, writes ignored.
REQ-019 Read is combinational: read_data = selected register when read_en=1, else 0.
REQ-020 Bypass: write_en=1 and write_addr==read_addr same cycle -> read_data returns post-write value of writable fields.
REQ-021 Writes commit at the clock edge; writable fields only: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC all; Count all; Compare all.
REQ-022 Status bit 22 (BEV) reads 1, read-only; all other unlisted bits read 0.
REQ-023 Count increments by 1 every second clock (internal toggle flop); wraps 0xFFFF_FFFF -> 0x0000_0000.
REQ-024 Count write overrides increment that cycle and clears the toggle.
REQ-025 Count==Compare (after update) sets timer flag; flag sticky until Compare is written; Compare write clears it same edge.
REQ-026 Cause IP[15:10] = registered hw_int[5:0] each cycle, IP[15] additionally ORed with timer flag.
REQ-027 Exception (exc_valid=1) with Status.EXL=0: EPC <= exc_delay_slot ? exc_pc-4 : exc_pc; Cause.BD(31) <= exc_delay_slot; Status.EXL <= 1; Cause.ExcCode[6:2] <= exc_code.
REQ-028 Exception with Status.EXL=1: only ExcCode updated; EPC, BD unchanged.
REQ-029 ERET: Status.EXL <= 0.
REQ-030 Priority on the same field, same edge: exc_valid > eret > write_en; write_en to non-conflicting fields still applies.
REQ-031 int_req = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]), combinational.

Reset
REQ-032 rst=1: Count, Compare, EPC, Cause = 0; Status = 0x0040_0000; timer flag and toggle = 0; int_req = 0.
REQ-033 Reset overrides exc_valid, eret, write_en in the same cycle.

Configuration
REQ-034 Macro CP0_TIMER_EN defined: Count/Compare and timer interrupt as REQ-023..025.
REQ-035 CP0_TIMER_EN undefined: Count and Compare read 0, writes ignored, no timer flag; IP[15] follows hw_int[5] only.

Verification
REQ-036 Reset, then read 12 -> 0x0040_0000; read 15 -> 0x0000_4220; read 3 -> 0.
REQ-037 Write Compare=10, Count=0 -> Cause bit 15 set ~20 cycles later, int_req=1 with Status=0x0000_8001; write Compare=10 -> bit 15 clears next edge.
REQ-038 exc_valid, exc_pc=0xBFC0_0100, delay_slot=1, code=8 -> EPC=0xBFC0_00FC, Cause=0x8000_0020, EXL=1; second exception code 4 -> EPC unchanged, ExcCode=4.
REQ-039 Same cycle write_en Status=0x0000_0003 and eret -> Status EXL=0, IE=1; same cycle exc_valid and eret -> EXL=1.
REQ-040 write_en/read_en both addr 14, data 0x1234_5678 -> read_data=0x1234_5678 same cycle.
REQ-041 Count write 0xFFFF_FFFF -> reads 0 two cycles later (wrap).
